// File: rtl/pc_attacker_pkg.sv
// Shared definitions for the PC attacker: cell codes, board geometry,
// FSM state type, LFSR seed and small decode helpers.
package pc_attacker_pkg;

    localparam logic [3:0] CELL_WATER = 4'h0;
    localparam logic [3:0] CELL_MISS  = 4'hE;
    localparam logic [3:0] CELL_HIT   = 4'hF;
    localparam logic [3:0] SHIP_MAX   = 4'd5;

    localparam int         BOARD_DIM   = 5;
    localparam logic [4:0] LAST_INDEX  = 5'd24;
    localparam logic [5:0] RETRY_LIMIT = 6'd32;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_PROBE,
        ST_SCAN,
        ST_WRITE,
        ST_DONE
    } state_t;

    // A cell already shot at holds either the miss or the hit marker.
    function automatic logic is_attacked(input logic [3:0] code);
        return (code == CELL_MISS) || (code == CELL_HIT);
    endfunction

    // Row-major index 0..24 -> {row[2:0], col[2:0]}.
    function automatic logic [5:0] index_to_xy(input logic [4:0] idx);
        logic [2:0] y;
        logic [2:0] x;
        if (idx >= 5'd20)      y = 3'd4;
        else if (idx >= 5'd15) y = 3'd3;
        else if (idx >= 5'd10) y = 3'd2;
        else if (idx >= 5'd5)  y = 3'd1;
        else                   y = 3'd0;
        x = 3'(idx - 5'(y) * 5'd5);
        return {y, x};
    endfunction

endpackage

// File: rtl/pc_attacker_lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Ports: clk, reset (sync, active-high, loads the seed), q[7:0] state.
module lfsr8
    import pc_attacker_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= LFSR_SEED;
        else       q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end

endmodule

// File: rtl/pc_attacker.sv
// PC attacker for a 5x5 battleship board. On turn_req it picks a random
// unattacked cell of the player board (falling back to a linear scan after
// 32 failed random tries), writes a miss/hit marker there and pulses
// turn_done.
// Ports:
//   clk, reset            clock, sync active-high reset
//   turn_req              start a PC turn (honoured only when idle)
//   cell_code             player-board code at (rd_x, rd_y), combinational
//   rd_x, rd_y            probed / target cell
//   wr_en, wr_code        one-cycle board write strobe and code
//   hit                   result of the last shot
//   turn_done             one-cycle end-of-turn pulse
//   busy                  turn in progress
//   player_hits           saturating count of ship cells hit
//   board_full            last turn found no unattacked cell
module pc_attacker
    import pc_attacker_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       turn_req,
    input  logic [3:0] cell_code,
    output logic [2:0] rd_x,
    output logic [2:0] rd_y,
    output logic       wr_en,
    output logic [3:0] wr_code,
    output logic       hit,
    output logic       turn_done,
    output logic       busy,
    output logic [3:0] player_hits,
    output logic       board_full
);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    state_t     state;
    logic [5:0] retry_cnt;
    logic [7:0] lfsr_q;
    logic       lfsr_unused;

    logic [4:0] pick_idx;
    logic [5:0] pick_xy;
    logic       cell_attacked;
    logic       cell_is_ship;
    logic [5:0] retry_next;
    logic       scan_last;
    logic [2:0] dim_last;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Only the low five bits feed the index; the rest just keep the sequence long.
    assign lfsr_unused   = ^lfsr_q[7:5];
    assign pick_idx      = lfsr_q[4:0];
    assign pick_xy       = index_to_xy(pick_idx);
    assign cell_attacked = is_attacked(cell_code);
    // Undefined codes 6..D are treated as water (a miss).
    assign cell_is_ship  = (cell_code >= 4'd1) && (cell_code <= SHIP_MAX);
    assign retry_next    = retry_cnt + 6'd1;
    assign dim_last      = 3'(BOARD_DIM - 1);
    assign scan_last     = (rd_x == dim_last) && (rd_y == dim_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            retry_cnt   <= '0;
            rd_x        <= '0;
            rd_y        <= '0;
            wr_en       <= 1'b0;
            wr_code     <= '0;
            hit         <= 1'b0;
            turn_done   <= 1'b0;
            busy        <= 1'b0;
            player_hits <= '0;
            board_full  <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            turn_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (turn_req) begin
                        state      <= ST_PICK;
                        retry_cnt  <= '0;
                        busy       <= 1'b1;
                        board_full <= 1'b0;
                    end
                end
                ST_PICK: begin
                    if (pick_idx <= LAST_INDEX) begin
                        rd_y  <= pick_xy[5:3];
                        rd_x  <= pick_xy[2:0];
                        state <= ST_PROBE;
                    end else begin
                        retry_cnt <= retry_next;
                        if (retry_next == RETRY_LIMIT) begin
                            rd_x  <= '0;
                            rd_y  <= '0;
                            state <= ST_SCAN;
                        end
                    end
                end
                // Both probing states look at the same combinational cell_code;
                // they only differ in what happens on an already-attacked cell.
                ST_PROBE, ST_SCAN: begin
                    if (!cell_attacked) begin
                        wr_en   <= 1'b1;
                        wr_code <= cell_is_ship ? CELL_HIT : CELL_MISS;
                        hit     <= cell_is_ship;
                        if (cell_is_ship) player_hits <= sat_inc4(player_hits);
                        state   <= ST_WRITE;
                    end else if (state == ST_PROBE) begin
                        retry_cnt <= retry_next;
                        if (retry_next == RETRY_LIMIT) begin
                            rd_x  <= '0;
                            rd_y  <= '0;
                            state <= ST_SCAN;
                        end else begin
                            state <= ST_PICK;
                        end
                    end else if (scan_last) begin
                        board_full <= 1'b1;
                        turn_done  <= 1'b1;
                        state      <= ST_DONE;
                    end else if (rd_x == dim_last) begin
                        rd_x <= '0;
                        rd_y <= rd_y + 3'd1;
                    end else begin
                        rd_x <= rd_x + 3'd1;
                    end
                end
                ST_WRITE: begin
                    turn_done <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pc_attacker.md
PC_ATTACKER -- requirements
Module: pc_attacker

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous reset.
REQ-002 The module SHALL expose these ports:
- turn_req  in  1  one-cycle pulse: the player's attack has finished and the PC must fire.
- cell_code  in  4  code of player-board cell at (rd_x, rd_y); combinational, valid in the same cycle.
- rd_x  out  3  column being probed, 0..4.
- rd_y  out  3  row being probed, 0..4.
- wr_en  out  1  one-cycle write strobe to the player board at (rd_x, rd_y).
- wr_code  out  4  code to write when wr_en is high.
- hit  out  1  result of the last shot: 1 = ship hit; held until the next shot.
- turn_done  out  1  one-cycle pulse: PC turn complete.
- busy  out  1  high from the cycle after turn_req is accepted until turn_done, inclusive.
- player_hits  out  4  running count of ship cells hit, saturating at 15.
- board_full  out  1  high if a turn found no unattacked cell.

Function
REQ-003 Cell codes SHALL be: 0 = water; 1..5 = ship id; 4'hE = miss; 4'hF = hit. A cell is "attacked" if its code is E or F.
REQ-004 An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) SHALL advance every cycle in every state except reset.
REQ-005 FSM states SHALL be IDLE, PICK, PROBE, SCAN, WRITE, DONE.
REQ-006 IDLE: turn_req=1 SHALL move the FSM to PICK and clear the retry counter; turn_req SHALL be ignored in every other state.
REQ-007 PICK: index = lfsr[4:0]. If index <= 24, then rd_x = index mod 5 and rd_y = index div 5, and the FSM SHALL go to PROBE. Otherwise the retry counter SHALL increment and the FSM SHALL stay in PICK.
REQ-008 PROBE: if cell_code is not attacked, the FSM SHALL go to WRITE. Otherwise the retry counter SHALL increment and the FSM SHALL return to PICK.
REQ-009 When the retry counter reaches 32, the FSM SHALL enter SCAN at index 0.
REQ-010 SCAN SHALL probe one index per cycle, 0..24 in row-major order. On the first unattacked cell the FSM SHALL go to WRITE. If index 24 is attacked, the FSM SHALL set board_full, go to DONE and issue no write.
REQ-011 WRITE SHALL assert wr_en for exactly one cycle, with rd_x/rd_y held at the target cell.
- If the cell code is 1..5: wr_code = F, hit = 1, player_hits increments (saturating at 15).
- If the cell code is 0: wr_code = E, hit = 0.
REQ-012 DONE SHALL pulse turn_done for one cycle and return to IDLE.
REQ-013 Minimum latency SHALL be 4 cycles from turn_req sampled to turn_done high, via PICK, PROBE, WRITE, DONE.
REQ-014 rd_x and rd_y SHALL stay within 0..4 at all times.
REQ-015 wr_en SHALL never assert for an attacked cell.
REQ-016 wr_en SHALL never assert more than once per turn.
REQ-017 A turn_req arriving in the same cycle as turn_done SHALL be ignored.

Reset
REQ-018 Reset SHALL take effect on the next rising edge. It SHALL force the following values:
- FSM to IDLE; LFSR to 8'hA5; retry counter to 0.
- rd_x = 0, rd_y = 0, wr_en = 0, wr_code = 0.
- hit = 0, turn_done = 0, busy = 0, player_hits = 0, board_full = 0.
REQ-019 Reset mid-turn SHALL abort the turn with no write and no turn_done pulse.

Structure
REQ-020 The cell-code constants (water, miss, hit), the board dimension 5, the state enum type and the LFSR seed SHALL live in the shared game package.
REQ-021 The LFSR SHALL be a separate sub-module named lfsr8 with ports clk, reset, q[7:0].

Verification
REQ-022 The bench SHALL cover these scenarios:
- Board all water, one turn_req: exactly one wr_en with wr_code = E; hit = 0; turn_done 4..~70 cycles later; player_hits = 0.
- 24 cells = E, cell (3,2) = ship 2, turn_req: a write at rd_x = 3, rd_y = 2 with wr_code = F; hit = 1; player_hits = 1.
- All 25 cells attacked, turn_req: no wr_en; board_full = 1; turn_done pulses once; FSM in IDLE.
- Second turn_req during busy: ignored; exactly one write and one turn_done.
- Reset asserted in PROBE: next cycle all outputs at reset values; no wr_en or turn_done follows.
- 20 turns against a board holding ships 1..5 (15 cells): no cell written twice, final player_hits equals the number of F writes, and player_hits <= 15.
